// File: rtl/fifo_word_serializer.sv
// Wide-to-narrow word serializer between an upstream FIFO head and a downstream FIFO.
// Optional macro WORD_SER_MSB_FIRST_EN emits the most significant slice first.
module fifo_word_serializer #(
    parameter int in_width  = 64,
    parameter int out_width = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic                 IN_EMPTY_N,
    input  logic [in_width-1:0]  IN_D,
    output logic                 IN_DEQ,
    input  logic                 OUT_FULL_N,
    output logic [out_width-1:0] OUT_D,
    output logic                 OUT_ENQ,
    output logic                 OUT_LAST,
    output logic                 BUSY
);

    localparam int ratio = in_width / out_width;
    localparam int CNT_W = (ratio > 1) ? $clog2(ratio) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ratio - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [CNT_W-1:0]    w_beat_cnt_nxt;
    logic [in_width-1:0] r_hold;
    logic                w_busy;
    logic                w_last;
    logic                w_enq;
    logic                w_deq;
    logic                w_load;
    int                  w_slice;
    logic [out_width-1:0] w_beat;

    assign w_busy = (r_state == SEND);
    assign w_last = w_busy && (r_beat_cnt == LAST_CNT);
    assign w_enq  = w_busy && OUT_FULL_N && !CLR;
    // Refilling on the last accepted beat keeps consecutive words gap-free.
    assign w_deq  = IN_EMPTY_N && !CLR && (!w_busy || (w_last && w_enq));

    assign IN_DEQ   = w_deq;
    assign OUT_ENQ  = w_enq;
    assign OUT_LAST = w_last;
    assign BUSY     = w_busy;
    assign OUT_D    = w_beat;

    always_comb begin
`ifdef WORD_SER_MSB_FIRST_EN
        w_slice = ratio - 1 - int'(r_beat_cnt);
`else
        w_slice = int'(r_beat_cnt);
`endif
        w_beat = out_width'(r_hold >> (w_slice * out_width));
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_load         = 1'b0;
        if (CLR) begin
            w_state_nxt    = IDLE;
            w_beat_cnt_nxt = '0;
        end else if (w_deq) begin
            w_state_nxt    = SEND;
            w_beat_cnt_nxt = '0;
            w_load         = 1'b1;
        end else if (w_enq) begin
            if (w_last) begin
                w_state_nxt    = IDLE;
                w_beat_cnt_nxt = '0;
            end else begin
                w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Held word is data only; BUSY qualifies it, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (!RST && w_load) begin
            r_hold <= IN_D;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(w_deq && !IN_EMPTY_N))
                else $warning("IN_DEQ asserted while IN_EMPTY_N=0");
            assert ((in_width % out_width) == 0)
                else $warning("in_width is not a multiple of out_width");
        end
    end
`endif

endmodule
